// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Definitions shared by the countdown timer sequencing controller and its
// helpers:
//   - ST_IDLE / ST_RUN / ST_PAUSE / ST_DONE : 2-bit state codes. These are
//     also the values on the `state` output.
//   - BCD_DIGIT_W / BCD_FIELD_W / BCD_TIME_W : widths of one BCD digit, one
//     MM or SS field, and the full MM:SS word.
//   - BCD_MAX : the largest legal MM or SS field value (59).
//   - bcd_time_t : MM:SS word split into its minutes and seconds fields.
// -----------------------------------------------------------------------------
package countdown_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_FIELD_W = 2 * BCD_DIGIT_W;
    localparam int BCD_TIME_W  = 2 * BCD_FIELD_W;

    localparam logic [BCD_FIELD_W-1:0] BCD_MAX = 8'h59;

    typedef struct packed {
        logic [BCD_FIELD_W-1:0] mins;
        logic [BCD_FIELD_W-1:0] secs;
    } bcd_time_t;

endpackage

// File: rtl/countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// countdown_ctrl_if
// Groups the signals between the countdown controller and its surroundings.
// Those surroundings are the one-pulse button logic, the 1 Hz strobe, the
// digit chain and the display.
//   master : the controller side.
//            Inputs:  tick, start_pause, clear, inc_min, inc_sec, cnt_value.
//            Outputs: preset, load, dec, running, alarm, state.
//   slave  : the environment side, with every direction reversed.
// -----------------------------------------------------------------------------
interface countdown_ctrl_if;
    import countdown_pkg::*;

    logic                  tick;
    logic                  start_pause;
    logic                  clear;
    logic                  inc_min;
    logic                  inc_sec;
    logic [BCD_TIME_W-1:0] cnt_value;
    logic [BCD_TIME_W-1:0] preset;
    logic                  load;
    logic                  dec;
    logic                  running;
    logic                  alarm;
    logic [1:0]            state;

    modport master (
        input  tick, start_pause, clear, inc_min, inc_sec, cnt_value,
        output preset, load, dec, running, alarm, state
    );

    modport slave (
        output tick, start_pause, clear, inc_min, inc_sec, cnt_value,
        input  preset, load, dec, running, alarm, state
    );

endinterface

// File: rtl/bcd60_inc.sv
// -----------------------------------------------------------------------------
// bcd60_inc
// Combinational increment of one 2-digit BCD field. The field counts
// 00..59, and 59 wraps to 00.
//   bcd_in  : current field value (BCD).
//   bcd_out : bcd_in + 1, wrapping to 00 after 59.
// A value at or above 59 (including illegal BCD codes) also returns 00, so
// a corrupted field recovers after one press.
// -----------------------------------------------------------------------------
module bcd60_inc
    import countdown_pkg::*;
(
    input  logic [BCD_FIELD_W-1:0] bcd_in,
    output logic [BCD_FIELD_W-1:0] bcd_out
);

    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] units;

    assign tens  = bcd_in[BCD_FIELD_W-1:BCD_DIGIT_W];
    assign units = bcd_in[BCD_DIGIT_W-1:0];

    always_comb begin
        bcd_out = '0;
        if (bcd_in >= BCD_MAX) begin
            bcd_out = '0;
        end else if (units >= 4'd9) begin
            // Units carry into the tens digit.
            bcd_out = {tens + 4'd1, 4'd0};
        end else begin
            bcd_out = {tens, units + 4'd1};
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Sequencing controller for an MM:SS countdown timer. It owns the preset
// value and the IDLE/RUN/PAUSE/DONE state machine. It decides when the
// seconds-units digit decrements and when the digit chain reloads.
//
// Parameters
//   ALARM_TICKS    : number of tick strobes that alarm stays high in DONE.
//   DEFAULT_PRESET : BCD MM:SS preset after reset.
// Ports
//   clk : system clock.
//   rst : asynchronous, active-high reset.
//   bus : countdown_ctrl_if.master
//         Inputs:  tick, start_pause, clear, inc_min, inc_sec, cnt_value.
//         Outputs: preset, load, dec, running, alarm, state.
// All outputs are registered except dec. dec is formed combinationally,
// so the digit chain decrements on the same edge that samples tick.
// -----------------------------------------------------------------------------
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int                    ALARM_TICKS    = 5,
    parameter logic [BCD_TIME_W-1:0] DEFAULT_PRESET = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    countdown_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(ALARM_TICKS + 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS - 1);

    logic [1:0]       state_q,     state_d;
    bcd_time_t        preset_q,    preset_d;
    logic             load_q,      load_d;
    logic             running_q,   running_d;
    logic             alarm_q,     alarm_d;
    logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;

    logic [BCD_FIELD_W-1:0] mins_inc;
    logic [BCD_FIELD_W-1:0] secs_inc;
    logic                   cnt_zero;
    logic                   preset_zero;

    bcd60_inc u_mins_inc (
        .bcd_in  (preset_q.mins),
        .bcd_out (mins_inc)
    );

    bcd60_inc u_secs_inc (
        .bcd_in  (preset_q.secs),
        .bcd_out (secs_inc)
    );

    assign cnt_zero    = (bus.cnt_value == '0);
    assign preset_zero = (preset_q == '0);

    // Next-state logic. The input priority is clear > start_pause > tick >
    // inc_*. tick has no effect in IDLE, so there it does not block an
    // inc_* pulse.
    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        load_d      = 1'b0;
        alarm_cnt_d = alarm_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    load_d = 1'b1;
                end else if (bus.start_pause) begin
                    // A zero preset has nothing to count, so start is ignored.
                    if (!preset_zero) begin
                        state_d = ST_RUN;
                    end
                end else if (bus.inc_min || bus.inc_sec) begin
                    if (bus.inc_min) begin
                        preset_d.mins = mins_inc;
                    end
                    if (bus.inc_sec) begin
                        preset_d.secs = secs_inc;
                    end
                    load_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                    load_d  = 1'b1;
                end else if (bus.start_pause) begin
                    state_d = ST_PAUSE;
                end else if (cnt_zero) begin
                    // Clear the counter on entry, so a tick in this same
                    // cycle never counts toward the alarm duration.
                    state_d     = ST_DONE;
                    alarm_cnt_d = '0;
                end
            end

            ST_PAUSE: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                    load_d  = 1'b1;
                end else if (bus.start_pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (bus.clear || bus.start_pause) begin
                    state_d     = ST_IDLE;
                    load_d      = 1'b1;
                    alarm_cnt_d = '0;
                end else if (bus.tick) begin
                    if (alarm_cnt_q == ALARM_LAST) begin
                        state_d     = ST_IDLE;
                        load_d      = 1'b1;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are decoded from the next state, so they change on
        // the same edge as the state register.
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            preset_q    <= bcd_time_t'(DEFAULT_PRESET);
            load_q      <= 1'b0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            load_q      <= load_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    // dec is not issued when start_pause or clear arrives with the tick.
    // It is also not issued at zero, so the chain never underflows.
    // load is only ever high in IDLE, so it cannot coincide with dec.
    assign bus.dec     = (state_q == ST_RUN) && bus.tick && !bus.clear &&
                         !bus.start_pause && !cnt_zero;
    assign bus.preset  = preset_q;
    assign bus.load    = load_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Self-checking bench for countdown_ctrl. A behavioural 4-digit BCD
// down-counter stands in for the digit chain. Expected values are queued
// before each stimulus step and retired against the DUT after it.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;
    import countdown_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    countdown_ctrl_if bus ();

    countdown_ctrl #(
        .ALARM_TICKS    (5),
        .DEFAULT_PRESET (16'h0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- digit chain model ----------------
    logic [15:0] chain_q;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] d [4];
        logic       borrow;
        d[0] = v[3:0];
        d[1] = v[7:4];
        d[2] = v[11:8];
        d[3] = v[15:12];
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (d[i] == 4'd0) begin
                    d[i] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    d[i] = d[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return {d[3], d[2], d[1], d[0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           chain_q <= 16'h0100;
        else if (bus.load) chain_q <= bus.preset;
        else if (bus.dec)  chain_q <= bcd_dec(chain_q);
    end
    assign bus.cnt_value = chain_q;

    // ---------------- monitors ----------------
    int load_count = 0;
    int overlap    = 0;
    always @(negedge clk) begin
        if (bus.load)             load_count <= load_count + 1;
        if (bus.load && bus.dec)  overlap    <= overlap + 1;
    end

    // ---------------- scoreboard ----------------
    typedef enum int {S_STATE, S_PRESET, S_LOAD, S_DEC, S_RUNNING, S_ALARM,
                      S_CNT, S_LOADCNT} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %-16s got %h expected %h  (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %-16s %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] obs_of(input sel_t sel);
        case (sel)
            S_STATE:   return 32'(bus.state);
            S_PRESET:  return 32'(bus.preset);
            S_LOAD:    return 32'(bus.load);
            S_DEC:     return 32'(bus.dec);
            S_RUNNING: return 32'(bus.running);
            S_ALARM:   return 32'(bus.alarm);
            S_CNT:     return 32'(bus.cnt_value);
            default:   return 32'(load_count);
        endcase
    endfunction

    task automatic sb_push(input sel_t sel, input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic retire();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, obs_of(it.sel), it.exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    typedef enum int {P_SP, P_CLR, P_INCM, P_INCS, P_TICK} pulse_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input pulse_t which);
        case (which)
            P_SP:    bus.start_pause = 1'b1;
            P_CLR:   bus.clear       = 1'b1;
            P_INCM:  bus.inc_min     = 1'b1;
            P_INCS:  bus.inc_sec     = 1'b1;
            default: bus.tick        = 1'b1;
        endcase
        step();
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.inc_min     = 1'b0;
        bus.inc_sec     = 1'b0;
        bus.tick        = 1'b0;
    endtask

    task automatic push_reset_vals(input string tag);
        sb_push(S_STATE,   {tag, "_state"},  ST_IDLE);
        sb_push(S_PRESET,  {tag, "_preset"}, 16'h0100);
        sb_push(S_LOAD,    {tag, "_load"},   0);
        sb_push(S_DEC,     {tag, "_dec"},    0);
        sb_push(S_RUNNING, {tag, "_run"},    0);
        sb_push(S_ALARM,   {tag, "_alarm"},  0);
        sb_push(S_CNT,     {tag, "_cnt"},    16'h0100);
    endtask

    int lc0;

    initial begin
        bus.tick = 1'b0; bus.start_pause = 1'b0; bus.clear = 1'b0;
        bus.inc_min = 1'b0; bus.inc_sec = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_reset_vals("rst");
        retire();
        rst = 1'b0;
        step();

        // 1: three inc_sec then one inc_min, each load one cycle wide
        lc0 = load_count;
        for (int i = 0; i < 3; i++) begin
            sb_push(S_PRESET, "inc_sec_preset", 32'(16'h0100 + i + 1));
            sb_push(S_LOAD,   "inc_sec_load",   1);
            pulse(P_INCS);
            retire();
            sb_push(S_LOAD, "load_one_cycle", 0);
            step();
            retire();
        end
        sb_push(S_PRESET, "inc_min_preset", 16'h0203);
        sb_push(S_LOAD,   "inc_min_load",   1);
        pulse(P_INCM);
        retire();
        sb_push(S_LOAD,    "load_one_cycle", 0);
        sb_push(S_LOADCNT, "t1_load_count",  32'(lc0 + 4));
        step();
        retire();

        // 2: seconds 59 wraps to 00 without touching minutes
        repeat (56) pulse(P_INCS);
        sb_push(S_PRESET, "sec_at_59", 16'h0259);
        retire();
        sb_push(S_PRESET, "sec_wrap", 16'h0200);
        sb_push(S_LOAD,   "sec_wrap_load", 1);
        pulse(P_INCS);
        retire();

        // 3: preset 00:03, run down to zero
        repeat (58) pulse(P_INCM);
        sb_push(S_PRESET, "min_wrap", 16'h0000);
        retire();
        repeat (3) pulse(P_INCS);
        step();
        sb_push(S_CNT, "chain_loaded", 16'h0003);
        retire();
        sb_push(S_STATE,   "start_state", ST_RUN);
        sb_push(S_RUNNING, "start_run",   1);
        pulse(P_SP);
        retire();
        for (int k = 0; k < 3; k++) begin
            bus.tick = 1'b1;
            #1;
            sb_push(S_DEC, "run_dec", 1);
            retire();
            step();
            bus.tick = 1'b0;
            sb_push(S_CNT, "run_cnt", 32'(2 - k));
            retire();
        end
        // zero reached: tick here issues no dec and is not counted
        bus.tick = 1'b1;
        #1;
        sb_push(S_DEC,   "zero_no_dec", 0);
        sb_push(S_STATE, "zero_still_run", ST_RUN);
        retire();
        step();
        bus.tick = 1'b0;
        sb_push(S_STATE,   "done_state", ST_DONE);
        sb_push(S_ALARM,   "done_alarm", 1);
        sb_push(S_RUNNING, "done_run",   0);
        sb_push(S_CNT,     "done_cnt",   16'h0000);
        retire();

        // 5: alarm lasts exactly five ticks
        lc0 = load_count;
        for (int t = 1; t <= 4; t++) begin
            step();
            sb_push(S_STATE, "alarm_hold_state", ST_DONE);
            sb_push(S_ALARM, "alarm_hold",       1);
            pulse(P_TICK);
            retire();
        end
        step();
        sb_push(S_STATE, "alarm_end_state", ST_IDLE);
        sb_push(S_ALARM, "alarm_end",       0);
        sb_push(S_LOAD,  "alarm_end_load",  1);
        pulse(P_TICK);
        retire();
        sb_push(S_CNT,     "reload_cnt",   16'h0003);
        sb_push(S_LOAD,    "reload_1cyc",  0);
        sb_push(S_LOADCNT, "reload_count", 32'(lc0 + 1));
        step();
        retire();

        // 4: pause with coincident tick, resume, back-to-back start_pause
        pulse(P_SP);
        pulse(P_TICK);
        sb_push(S_CNT, "pre_pause_cnt", 16'h0002);
        retire();
        bus.start_pause = 1'b1;
        bus.tick = 1'b1;
        #1;
        sb_push(S_DEC, "sp_tick_no_dec", 0);
        retire();
        step();
        bus.start_pause = 1'b0;
        bus.tick = 1'b0;
        sb_push(S_STATE,   "pause_state", ST_PAUSE);
        sb_push(S_RUNNING, "pause_run",   0);
        sb_push(S_CNT,     "pause_cnt",   16'h0002);
        retire();
        bus.tick = 1'b1;
        #1;
        sb_push(S_DEC, "pause_no_dec", 0);
        retire();
        step();
        bus.tick = 1'b0;
        sb_push(S_CNT, "pause_hold_cnt", 16'h0002);
        retire();
        sb_push(S_STATE, "resume_state", ST_RUN);
        pulse(P_SP);
        retire();
        sb_push(S_STATE, "b2b_pause", ST_PAUSE);
        pulse(P_SP);
        retire();
        sb_push(S_STATE, "clear_state", ST_IDLE);
        sb_push(S_LOAD,  "clear_load",  1);
        pulse(P_CLR);
        retire();
        sb_push(S_CNT, "clear_cnt", 16'h0003);
        step();
        retire();

        // 6: reset in RUN at 00:42, then zero preset cannot start
        repeat (39) pulse(P_INCS);
        step();
        sb_push(S_CNT, "chain_0042", 16'h0042);
        retire();
        sb_push(S_STATE, "run_0042", ST_RUN);
        pulse(P_SP);
        retire();
        #2;
        bus.tick = 1'b1;
        rst = 1'b1;
        #1;
        push_reset_vals("midrst");
        retire();
        bus.tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        repeat (59) pulse(P_INCM);
        sb_push(S_PRESET, "zero_preset", 16'h0000);
        retire();
        sb_push(S_STATE,   "zero_start_state", ST_IDLE);
        sb_push(S_RUNNING, "zero_start_run",   0);
        pulse(P_SP);
        retire();

        step();
        check_val("load_dec_overlap", 32'(overlap), 0);
        check_val("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the MM:SS countdown timer datapath, a chain of four BCD down-counting digits with borrow ripple. It owns the preset value and the run/pause/done state machine. It decides when the least-significant digit decrements, and when the chain reloads. It sits between the debounced one-pulse button logic and the digit chain, and drives the alarm indicator.

## Interface
- ALARM_TICKS, 5: number of `tick` strobes the alarm stays asserted in DONE.
- DEFAULT_PRESET, 16'h0100: BCD MM:SS preset after reset (01:00).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle strobe, once per second.
- start_pause  in  1  one-cycle pulse; start/resume/pause/acknowledge.
- clear  in  1  one-cycle pulse; abort to IDLE.
- inc_min  in  1  one-cycle pulse; preset minutes +1 (IDLE only).
- inc_sec  in  1  one-cycle pulse; preset seconds +1 (IDLE only).
- cnt_value  in  16  current BCD MM:SS from the digit chain.
- preset  out  16  BCD MM:SS reload value for the digit chain.
- load  out  1  one-cycle reload strobe to the digit chain.
- dec  out  1  decrement enable to the seconds-units digit.
- running  out  1  high in RUN.
- alarm  out  1  high in DONE.
- state  out  2  current state code, for display/debug.

## Operation
- States:
  - IDLE=0
  - RUN=1
  - PAUSE=2
  - DONE=3
- Input priority in every state: clear > start_pause > tick > inc_*.
- **IDLE:**
  - inc_min: minutes field (preset[15:8]) +1 in BCD, 59 wraps to 00.
  - inc_sec: same for seconds (preset[7:0]). Seconds never carry into minutes.
  - Any preset change asserts load.
  - start_pause with preset != 0 goes to RUN. start_pause with preset == 0 is ignored.
  - clear asserts load and stays in IDLE.
- **RUN:**
  - dec = tick & (cnt_value != 0).
  - cnt_value == 0 goes to DONE; no dec is issued at zero.
  - start_pause goes to PAUSE; dec is suppressed in that cycle even if tick is present.
  - clear goes to IDLE with load.
- **PAUSE:**
  - dec = 0.
  - start_pause goes to RUN.
  - clear goes to IDLE with load.
- **DONE:**
  - alarm = 1. An internal alarm counter is cleared on entry and counts ticks.
  - On the ALARM_TICKS-th tick, go to IDLE with load.
  - start_pause or clear goes to IDLE with load immediately.
- inc_min/inc_sec are ignored outside IDLE.
- The preset is unchanged by running, so every return to IDLE reloads the last preset.
- Reset mid-operation: all state is discarded, preset returns to DEFAULT_PRESET, and state returns to IDLE. No load is issued; the digit chain resets to the same value through its own reset.

## Timing
- Reset values:
  - state = IDLE
  - preset = DEFAULT_PRESET
  - load = 0, dec = 0, running = 0, alarm = 0
  - alarm counter = 0
- state, preset, load, running and alarm are registered. They update on the clk edge following the triggering input.
- load is high for exactly one cycle, the cycle after the event. It is never asserted together with dec.
- dec is combinational from tick, state and cnt_value, so the digit chain decrements on the same edge that samples tick.
- RUN to DONE happens one cycle after cnt_value first reads 0000.
- A tick coinciding with the RUN to DONE transition is not counted toward ALARM_TICKS.
- Back-to-back pulses are each honoured: start_pause on consecutive cycles goes RUN, then PAUSE.

## Structure
- Shared package `countdown_pkg` holds:
  - state codes ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE
  - BCD field widths
  - the constant BCD_MAX = 8'h59
- Sub-module `bcd60_inc`: combinational 2-digit BCD increment with 59 to 00 wrap. It is instantiated twice, for minutes and seconds.
- Alarm tick counter width is $clog2(ALARM_TICKS+1).

## Test plan
1. Reset, then 3× inc_sec, then 1× inc_min → preset = 16'h0203. Four load pulses, each one cycle wide.
2. Preset seconds 59, then inc_sec → seconds 00; minutes unchanged; preset = 16'h0200.
3. Preset 00:03, start_pause, 3 ticks with the chain model attached → dec on each tick, cnt_value 0002, 0001, 0000. DONE on the cycle after 0000; alarm=1; running=0.
4. In RUN, start_pause and tick in the same cycle → state PAUSE, dec=0, cnt_value unchanged. Further ticks give no dec. start_pause resumes RUN.
5. In DONE with ALARM_TICKS=5 → alarm high for exactly 5 ticks, then IDLE. load pulses once; cnt_value returns to the preset.
6. Assert rst while RUN at 00:42 → all outputs immediately at reset values, state IDLE, preset 16'h0100. Preset 0000 plus start_pause → stays IDLE.
